// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-side operand selection (forwarding + immediate mux).
// Optional macro ID_EX_FORWARD_EN enables the MEM/WB forwarding muxes; without it operands come straight from the register.
module id_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic             valid_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic [2:0]       alucontrol_d,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [RADDR-1:0] rs_d,
  input  logic [RADDR-1:0] rt_d,
  input  logic [RADDR-1:0] rd_d,
  input  logic [1:0]       forward_ae,
  input  logic [1:0]       forward_be,
  input  logic [WIDTH-1:0] aluout_m,
  input  logic [WIDTH-1:0] result_w,
  output logic [WIDTH-1:0] srca_e,
  output logic [WIDTH-1:0] srcb_e,
  output logic [2:0]       alucontrol_e,
  output logic [WIDTH-1:0] writedata_e,
  output logic [RADDR-1:0] writereg_e,
  output logic [RADDR-1:0] rs_e,
  output logic [RADDR-1:0] rt_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic             memwrite_e,
  output logic             valid_e
);

  logic             r_valid;
  logic             r_regwrite;
  logic             r_memtoreg;
  logic             r_memwrite;
  logic             r_alusrc;
  logic             r_regdst;
  logic [2:0]       r_alucontrol;
  logic [WIDTH-1:0] r_rd1;
  logic [WIDTH-1:0] r_rd2;
  logic [WIDTH-1:0] r_signimm;
  logic [RADDR-1:0] r_rs;
  logic [RADDR-1:0] r_rt;
  logic [RADDR-1:0] r_rd;

  logic [WIDTH-1:0] w_srca;
  logic [WIDTH-1:0] w_writedata;

  // Reset and flush both load a bubble; stall holds; otherwise capture decode.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      r_valid      <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_alusrc     <= 1'b0;
      r_regdst     <= 1'b0;
      r_alucontrol <= 3'b000;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_signimm    <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
    end else if (!stall_e) begin
      r_valid      <= valid_d;
      r_regwrite   <= regwrite_d;
      r_memtoreg   <= memtoreg_d;
      r_memwrite   <= memwrite_d;
      r_alusrc     <= alusrc_d;
      r_regdst     <= regdst_d;
      r_alucontrol <= alucontrol_d;
      r_rd1        <= rd1_d;
      r_rd2        <= rd2_d;
      r_signimm    <= signimm_d;
      r_rs         <= rs_d;
      r_rt         <= rt_d;
      r_rd         <= rd_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Select 11 is reserved and falls back to the register value.
  always_comb begin
    w_srca      = r_rd1;
    w_writedata = r_rd2;
    case (forward_ae)
      2'b01:   w_srca = result_w;
      2'b10:   w_srca = aluout_m;
      default: w_srca = r_rd1;
    endcase
    case (forward_be)
      2'b01:   w_writedata = result_w;
      2'b10:   w_writedata = aluout_m;
      default: w_writedata = r_rd2;
    endcase
  end
`else
  // Hazard unit stalls on every RAW hazard, so forward sources are ignored.
  logic w_unused;
  assign w_unused    = ^{forward_ae, forward_be, aluout_m, result_w};
  assign w_srca      = r_rd1;
  assign w_writedata = r_rd2;
`endif

  assign srca_e       = w_srca;
  assign writedata_e  = w_writedata;
  assign srcb_e       = r_alusrc ? r_signimm : w_writedata;
  assign writereg_e   = r_regdst ? r_rd : r_rt;
  assign alucontrol_e = r_alucontrol;
  assign rs_e         = r_rs;
  assign rt_e         = r_rt;
  assign regwrite_e   = r_regwrite;
  assign memtoreg_e   = r_memtoreg;
  assign memwrite_e   = r_memwrite;
  assign valid_e      = r_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed steps plus randomized traffic against an instruction-record model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e;
  logic        valid_d, regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [2:0]  alucontrol_d;
  logic [31:0] rd1_d, rd2_d, signimm_d, aluout_m, result_w;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic [1:0]  forward_ae, forward_be;
  logic [31:0] srca_e, srcb_e, writedata_e;
  logic [2:0]  alucontrol_e;
  logic [4:0]  writereg_e, rs_e, rt_e;
  logic        regwrite_e, memtoreg_e, memwrite_e, valid_e;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid, regwrite, memtoreg, memwrite, alusrc, regdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } instr_t;

  instr_t m_e;   // instruction the model believes sits in E
  instr_t cur_d; // instruction currently presented on the decode inputs

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .valid_d(valid_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
    .memwrite_d(memwrite_d), .alusrc_d(alusrc_d), .regdst_d(regdst_d),
    .alucontrol_d(alucontrol_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d), .forward_ae(forward_ae), .forward_be(forward_be),
    .aluout_m(aluout_m), .result_w(result_w), .srca_e(srca_e), .srcb_e(srcb_e),
    .alucontrol_e(alucontrol_e), .writedata_e(writedata_e), .writereg_e(writereg_e),
    .rs_e(rs_e), .rt_e(rt_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .memwrite_e(memwrite_e), .valid_e(valid_e)
  );

  always #5 clk = ~clk;

  function automatic instr_t bubble();
    instr_t b;
    b = '{valid:1'b0, regwrite:1'b0, memtoreg:1'b0, memwrite:1'b0, alusrc:1'b0,
          regdst:1'b0, alu:3'b000, rd1:32'h0, rd2:32'h0, imm:32'h0, rs:5'h0, rt:5'h0, rd:5'h0};
    return b;
  endfunction

  function automatic instr_t rand_instr();
    instr_t x;
    x.valid = 1'($urandom); x.regwrite = 1'($urandom); x.memtoreg = 1'($urandom);
    x.memwrite = 1'($urandom); x.alusrc = 1'($urandom); x.regdst = 1'($urandom);
    x.alu = 3'($urandom); x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
    x.rs = 5'($urandom); x.rt = 5'($urandom); x.rd = 5'($urandom);
    return x;
  endfunction

  task automatic drive_d(input instr_t x);
    cur_d = x;
    valid_d = x.valid; regwrite_d = x.regwrite; memtoreg_d = x.memtoreg;
    memwrite_d = x.memwrite; alusrc_d = x.alusrc; regdst_d = x.regdst;
    alucontrol_d = x.alu; rd1_d = x.rd1; rd2_d = x.rd2; signimm_d = x.imm;
    rs_d = x.rs; rt_d = x.rt; rd_d = x.rd;
  endtask

  // Value selected by a forward code when forwarding is built in.
  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] own);
`ifdef ID_EX_FORWARD_EN
    if (sel == 2'b01) return result_w;
    if (sel == 2'b10) return aluout_m;
`endif
    return own;
  endfunction

  // One clock edge; the model advances by the reset > flush > stall > load rule.
  task automatic tick();
    @(posedge clk);
    if (reset || flush_e) m_e = bubble();
    else if (!stall_e)    m_e = cur_d;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] wd;
    wd = pick(forward_be, m_e.rd2);
    chk({tag, ".srca"}, srca_e, pick(forward_ae, m_e.rd1));
    chk({tag, ".wdata"}, writedata_e, wd);
    chk({tag, ".srcb"}, srcb_e, m_e.alusrc ? m_e.imm : wd);
    chk({tag, ".alu"}, 32'(alucontrol_e), 32'(m_e.alu));
    chk({tag, ".wreg"}, 32'(writereg_e), 32'(m_e.regdst ? m_e.rd : m_e.rt));
    chk({tag, ".rs"}, 32'(rs_e), 32'(m_e.rs));
    chk({tag, ".rt"}, 32'(rt_e), 32'(m_e.rt));
    chk({tag, ".ctl"}, 32'({valid_e, regwrite_e, memtoreg_e, memwrite_e}),
        32'({m_e.valid, m_e.regwrite, m_e.memtoreg, m_e.memwrite}));
  endtask

  initial begin
    instr_t x;
    m_e = bubble();
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
    forward_ae = 2'b00; forward_be = 2'b00; aluout_m = 32'h0; result_w = 32'h0;

    // Reset held two cycles with nonzero decode inputs.
    x = rand_instr(); x.valid = 1'b1; x.regwrite = 1'b1; x.alu = 3'b111; x.regdst = 1'b1; x.rd = 5'd3;
    drive_d(x);
    tick(); tick();
    check_all("reset");
    chk("reset.valid", 32'(valid_e), 32'd0);
    chk("reset.wreg0", 32'(writereg_e), 32'd0);
    reset = 1'b0;

    // Plain register operands.
    x = bubble(); x.valid = 1'b1; x.rd1 = 32'h12345678; x.rd2 = 32'h87654321; x.alu = 3'b001;
    drive_d(x);
    tick();
    check_all("load");
    chk("load.srca_k", srca_e, 32'h12345678);
    chk("load.srcb_k", srcb_e, 32'h87654321);

    // Immediate operand B; store data still rd2.
    x.alusrc = 1'b1; x.imm = 32'hFFFFFFF6; x.rd2 = 32'd5;
    drive_d(x);
    tick();
    check_all("imm");
    chk("imm.srcb_k", srcb_e, 32'hFFFFFFF6);
    chk("imm.wdata_k", writedata_e, 32'd5);

    // Forwarding on a held instruction with rd1=100.
    x = bubble(); x.valid = 1'b1; x.rd1 = 32'd100;
    drive_d(x);
    tick();
    stall_e = 1'b1;
    tick();
    aluout_m = 32'd123; result_w = 32'd77;
    forward_ae = 2'b10; #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd.mem", srca_e, 32'd123);
`else
    chk("fwd.mem", srca_e, 32'd100);
`endif
    forward_ae = 2'b01; #1;
`ifdef ID_EX_FORWARD_EN
    chk("fwd.wb", srca_e, 32'd77);
`else
    chk("fwd.wb", srca_e, 32'd100);
`endif
    forward_ae = 2'b11; #1;
    chk("fwd.rsv", srca_e, 32'd100);
    forward_ae = 2'b00; stall_e = 1'b0;

    // Stall three cycles while decode changes.
    x = rand_instr(); x.regdst = 1'b1; x.rd = 5'd9; x.valid = 1'b1;
    drive_d(x);
    tick();
    stall_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_d(rand_instr());
      tick();
      check_all("stall");
      chk("stall.wreg9", 32'(writereg_e), 32'd9);
    end

    // Flush wins over stall.
    x = rand_instr(); x.valid = 1'b1; x.regwrite = 1'b1; x.memwrite = 1'b1;
    stall_e = 1'b0; drive_d(x); tick();
    stall_e = 1'b1; flush_e = 1'b1;
    tick();
    check_all("flush");
    chk("flush.ctl0", 32'({valid_e, regwrite_e, memwrite_e}), 32'd0);
    stall_e = 1'b0; flush_e = 1'b0;

    // Randomized traffic, including mid-cycle forward changes and occasional reset.
    for (int i = 0; i < 300; i++) begin
      reset   = ($urandom_range(0, 19) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      stall_e = ($urandom_range(0, 3) == 0);
      drive_d(rand_instr());
      forward_ae = 2'($urandom); forward_be = 2'($urandom);
      aluout_m = $urandom; result_w = $urandom;
      tick();
      check_all("rand");
      forward_ae = 2'($urandom); forward_be = 2'($urandom);
      aluout_m = $urandom; result_w = $urandom;
      #1;
      check_all("rand_fwd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
